// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment scanner: segment encoding
// table, nibble decoder and counter-width rule.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // {g,f,e,d,c,b,a} patterns, entry 15 first so SEG_TABLE[n] decodes nibble n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seven_seg_rom.sv
// Combinational hex nibble to {g..a} segment decoder.
module seven_seg_rom
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed 7-segment driver with frame-synchronous value updates.
// Optional macro SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never).
module seven_segment_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                  clk,
  input  logic                  rst_L,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  output logic                  ready,
  output logic [DIGITS-1:0]     an_L,
  output logic [6:0]            ssOut,
  output logic [6:0]            ssOut_L,
  output logic                  dp_L
);

  import ssd_pkg::*;

  localparam int CW = clog2_min1(PRESCALE);
  localparam int DW = clog2_min1(DIGITS);
  localparam logic [CW-1:0] PRE_LAST = CW'(PRESCALE - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);

  logic [CW-1:0]       pre_cnt;
  logic [DW-1:0]       digit;
  logic [4*DIGITS-1:0] stage_value;
  logic [4*DIGITS-1:0] shadow_value;
  logic [DIGITS-1:0]   stage_dp;
  logic [DIGITS-1:0]   shadow_dp;
  logic                pending;

  logic       pre_wrap;
  logic       frame_end;
  logic       accept;
  logic [3:0] cur_nibble;
  logic       cur_dp;
  logic       blank;
  logic [6:0] rom_seg;

  assign pre_wrap  = (pre_cnt == PRE_LAST);
  assign frame_end = pre_wrap && (digit == DIG_LAST);
  assign accept    = load && !pending;
  assign ready     = !pending;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      pre_cnt <= '0;
      digit   <= '0;
    end else begin
      if (pre_wrap) begin
        pre_cnt <= '0;
        digit   <= (digit == DIG_LAST) ? '0 : digit + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  // NOTE: staging and shadow registers are reset so an update pending when
  // rst_L falls is discarded instead of surfacing after reset.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      stage_value  <= '0;
      stage_dp     <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
      pending      <= 1'b0;
    end else begin
      if (accept) begin
        stage_value <= value;
        stage_dp    <= dp;
        pending     <= 1'b1;
      end else if (frame_end && pending) begin
        pending <= 1'b0;
      end
      // accept implies pending==0, so the shadow copy never races a new stage.
      if (frame_end && pending) begin
        shadow_value <= stage_value;
        shadow_dp    <= stage_dp;
      end
    end
  end

  // NOTE: defaults are assigned before the loop so no path leaves the mux
  // outputs unassigned, which would otherwise infer latches.
  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit == DW'(i)) begin
        cur_nibble = shadow_value[4*i +: 4];
        cur_dp     = shadow_dp[i];
      end
    end
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every more significant nibble are zero.
  always_comb begin
    blank = 1'b0;
    for (int i = 1; i < DIGITS; i++) begin
      if ((digit == DW'(i)) && ((shadow_value >> (4*i)) == '0)) begin
        blank = 1'b1;
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  seven_seg_rom u_rom (
    .nibble (cur_nibble),
    .seg    (rom_seg)
  );

  // Output stage: one cycle behind the digit counter; all pins share this edge.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      an_L  <= '1;
      ssOut <= SEG_BLANK;
      dp_L  <= 1'b1;
    end else if (en) begin
      an_L  <= ~(DIGITS'(1) << digit);
      ssOut <= blank ? SEG_BLANK : rom_seg;
      dp_L  <= ~cur_dp;
    end else begin
      an_L  <= '1;
      ssOut <= SEG_BLANK;
      dp_L  <= 1'b1;
    end
  end

  assign ssOut_L = ~ssOut;

endmodule
